// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen constants, coordinate widths and checker state enum
package game_pkg;

  localparam int SCREEN_WIDTH  = 400;
  localparam int SCREEN_HEIGHT = 600;
  localparam int BLOCK_SIZE    = 8;

  localparam int X_W = $clog2(SCREEN_WIDTH);
  localparam int Y_W = $clog2(SCREEN_HEIGHT);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    DRIVE,
    SAMPLE,
    DONE
  } checker_state_t;

endpackage

// File: rtl/coord_clamp.sv
// rtl/coord_clamp.sv - one-axis add-and-saturate to the last on-screen pixel
module coord_clamp #(
  parameter int W     = 9,
  parameter int LIMIT = 400
) (
  input  logic [W-1:0] i_base,
  input  logic [W-1:0] i_offset,
  output logic [W-1:0] o_coord
);

  localparam logic [W:0] MAX_C = (W+1)'(LIMIT - 1);

  logic [W:0] sum;

  // Sum carries one extra bit so an overflow saturates instead of wrapping to a low coordinate
  always_comb begin
    sum     = {1'b0, i_base} + {1'b0, i_offset};
    o_coord = (sum > MAX_C) ? MAX_C[W-1:0] : sum[W-1:0];
  end

endmodule

// File: rtl/player_safety_checker.sv
// rtl/player_safety_checker.sv - walks the four player corners through the safe-zone map query port
module player_safety_checker
  import game_pkg::*;
#(
  parameter int SCREEN_WIDTH  = game_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = game_pkg::SCREEN_HEIGHT,
  parameter int PLAYER_SIZE   = 16
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic                             i_check_valid,
  output logic                             o_check_ready,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]  i_player_x,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] i_player_y,
  output logic                             o_result_valid,
  output logic                             o_player_safe,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  o_query_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] o_query_y,
  input  logic                             i_zone_rdy,
  input  logic                             i_is_safe
);

  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  localparam logic [XW-1:0] OFF_X = XW'(PLAYER_SIZE - 1);
  localparam logic [YW-1:0] OFF_Y = YW'(PLAYER_SIZE - 1);

  checker_state_t state_q, state_d;
  logic [XW-1:0]  px_q, px_d, qx_q, qx_d;
  logic [YW-1:0]  py_q, py_d, qy_q, qy_d;
  logic [1:0]     k_q, k_d;
  logic           acc_q, acc_d;
  logic           safe_q, safe_d;

  logic [XW-1:0]  off_x, corner_x;
  logic [YW-1:0]  off_y, corner_y;

  // Corner k: bit 0 selects the right edge, bit 1 selects the bottom edge
  always_comb begin
    off_x = k_q[0] ? OFF_X : '0;
    off_y = k_q[1] ? OFF_Y : '0;
  end

  coord_clamp #(.W(XW), .LIMIT(SCREEN_WIDTH)) u_clamp_x (
    .i_base   (px_q),
    .i_offset (off_x),
    .o_coord  (corner_x)
  );

  coord_clamp #(.W(YW), .LIMIT(SCREEN_HEIGHT)) u_clamp_y (
    .i_base   (py_q),
    .i_offset (off_y),
    .o_coord  (corner_y)
  );

  // Next-state and datapath: one corner per DRIVE/SAMPLE pair, restart from corner 0 if the map drops ready
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    k_d     = k_q;
    acc_d   = acc_q;
    safe_d  = safe_q;
    case (state_q)
      IDLE: begin
        if (i_check_valid) begin
          px_d    = i_player_x;
          py_d    = i_player_y;
          k_d     = 2'd0;
          acc_d   = 1'b1;
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (i_zone_rdy) state_d = DRIVE;
      end
      DRIVE: begin
        qx_d    = corner_x;
        qy_d    = corner_y;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        if (!i_zone_rdy) begin
          k_d     = 2'd0;
          acc_d   = 1'b1;
          state_d = WAIT_RDY;
        end else begin
          acc_d = acc_q & i_is_safe;
          if (!i_is_safe || k_q == 2'd3) begin
            // Verdict is registered here so it is already valid during the DONE pulse
            safe_d  = acc_q & i_is_safe;
            state_d = DONE;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = DRIVE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      px_q    <= '0;
      py_q    <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      k_q     <= 2'd0;
      acc_q   <= 1'b1;
      safe_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      safe_q  <= safe_d;
    end
  end

  assign o_check_ready  = (state_q == IDLE);
  assign o_result_valid = (state_q == DONE);
  assign o_player_safe  = safe_q;
  assign o_query_x      = qx_q;
  assign o_query_y      = qy_q;

endmodule

// File: tb/tb_player_safety_checker.sv
// tb/tb_player_safety_checker.sv - self-checking bench for player_safety_checker
module tb_player_safety_checker;
  import game_pkg::*;

  localparam int W  = SCREEN_WIDTH;
  localparam int H  = SCREEN_HEIGHT;
  localparam int P  = 16;
  localparam int XW = X_W;
  localparam int YW = Y_W;

  logic          clk = 1'b0;
  logic          arst;
  logic          i_check_valid;
  logic          o_check_ready;
  logic [XW-1:0] i_player_x;
  logic [YW-1:0] i_player_y;
  logic          o_result_valid;
  logic          o_player_safe;
  logic [XW-1:0] o_query_x;
  logic [YW-1:0] o_query_y;
  logic          i_zone_rdy;
  logic          i_is_safe;

  player_safety_checker #(
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H),
    .PLAYER_SIZE   (P)
  ) dut (
    .clk            (clk),
    .arst           (arst),
    .i_check_valid  (i_check_valid),
    .o_check_ready  (o_check_ready),
    .i_player_x     (i_player_x),
    .i_player_y     (i_player_y),
    .o_result_valid (o_result_valid),
    .o_player_safe  (o_player_safe),
    .o_query_x      (o_query_x),
    .o_query_y      (o_query_y),
    .i_zone_rdy     (i_zone_rdy),
    .i_is_safe      (i_is_safe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int map_mode = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Map model: mode 1 has one unsafe cell containing (115,215), mode 2 one containing (100,200)
  function automatic bit map_safe(input int mode, input int x, input int y);
    int cx = x / BLOCK_SIZE;
    int cy = y / BLOCK_SIZE;
    case (mode)
      1:       return !(cx == 115 / BLOCK_SIZE && cy == 215 / BLOCK_SIZE);
      2:       return !(cx == 100 / BLOCK_SIZE && cy == 200 / BLOCK_SIZE);
      default: return 1'b1;
    endcase
  endfunction

  assign i_is_safe = map_safe(map_mode, int'(o_query_x), int'(o_query_y));

  function automatic int clampi(input int v, input int lim);
    return (v > lim - 1) ? lim - 1 : v;
  endfunction

  // Transaction-level model: on accept, precompute the corners the map will see, how many are
  // visited before the first unsafe one, and the verdict; then expect queries at accept+3,+5,..
  // and the result pulse at accept + 2*n + 2 (map always ready while the model is enabled)
  bit model_en = 1'b0;
  bit m_busy   = 1'b0;
  bit m_last   = 1'b0;
  bit m_verdict;
  int m_start, m_n;
  int m_cx[4];
  int m_cy[4];

  initial forever begin
    int t;
    @(negedge clk);
    if (model_en) begin
      chk("model_ready", int'(o_check_ready), int'(!m_busy));
      if (m_busy) begin
        t = cyc - m_start;
        chk("model_result_valid", int'(o_result_valid), int'(t == 2 * m_n + 2));
        if (t >= 3 && (t % 2) == 1 && (t - 3) / 2 < m_n) begin
          chk("model_query_x", int'(o_query_x), m_cx[(t - 3) / 2]);
          chk("model_query_y", int'(o_query_y), m_cy[(t - 3) / 2]);
        end
        if (t == 2 * m_n + 2) begin
          chk("model_verdict", int'(o_player_safe), int'(m_verdict));
          m_last = m_verdict;
          m_busy = 1'b0;
        end
      end else begin
        chk("model_idle_valid", int'(o_result_valid), 0);
        chk("model_held_verdict", int'(o_player_safe), int'(m_last));
        if (i_check_valid) begin
          m_verdict = 1'b1;
          m_n       = 4;
          for (int k = 0; k < 4; k++) begin
            m_cx[k] = clampi(int'(i_player_x) + ((k % 2 == 1) ? P - 1 : 0), W);
            m_cy[k] = clampi(int'(i_player_y) + ((k / 2 == 1) ? P - 1 : 0), H);
            if (m_verdict && !map_safe(map_mode, m_cx[k], m_cy[k])) begin
              m_verdict = 1'b0;
              m_n       = k + 1;
            end
          end
          m_busy  = 1'b1;
          m_start = cyc;
        end
      end
    end
  end

  // One request; ready is held low for relative cycles lo_from..lo_to-1; hand-computed latency/verdict
  task automatic do_run(input string name, input int x, input int y, input int lo_from, input int lo_to,
                        input int exp_lat, input int exp_safe, input int hold_x, input int hold_y);
    int pulses = 0;
    int lat = -1;
    int safe_at = -1;
    @(posedge clk); #1;
    i_player_x    = XW'(x);
    i_player_y    = YW'(y);
    i_check_valid = 1'b1;
    i_zone_rdy    = (lo_from <= 0 && 0 < lo_to) ? 1'b0 : 1'b1;
    for (int t = 1; t <= 24; t++) begin
      @(posedge clk); #1;
      i_check_valid = 1'b0;
      i_zone_rdy    = (lo_from <= t && t < lo_to) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (hold_x >= 0 && t <= lo_to) begin
        chk({name, "_hold_x"}, int'(o_query_x), hold_x);
        chk({name, "_hold_y"}, int'(o_query_y), hold_y);
      end
      if (o_result_valid) begin
        pulses++;
        if (lat < 0) begin
          lat     = t;
          safe_at = int'(o_player_safe);
        end
      end
    end
    i_zone_rdy = 1'b1;
    chk({name, "_pulses"}, pulses, 1);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_safe"}, safe_at, exp_safe);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int pulses;
    arst          = 1'b1;
    i_check_valid = 1'b0;
    i_player_x    = '0;
    i_player_y    = '0;
    i_zone_rdy    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", int'(o_check_ready), 1);
    chk("reset_result_valid", int'(o_result_valid), 0);
    chk("reset_safe", int'(o_player_safe), 0);
    chk("reset_query_x", int'(o_query_x), 0);
    chk("reset_query_y", int'(o_query_y), 0);
    @(posedge clk); #1;
    arst     = 1'b0;
    m_last   = 1'b0;
    model_en = 1'b1;
    repeat (2) @(posedge clk);

    map_mode = 0;
    do_run("all_safe", 100, 200, 0, 0, 10, 1, -1, -1);

    // Ready manipulation: model is transaction-only for an always-ready map, so it sits these out
    model_en = 1'b0;
    do_run("rdy_late", 100, 200, 0, 6, 15, 1, 115, 215);
    do_run("rdy_drop", 100, 200, 7, 8, 17, 1, -1, -1);
    m_busy   = 1'b0;
    m_last   = 1'b1;
    model_en = 1'b1;

    map_mode = 1;
    do_run("unsafe_corner3", 100, 200, 0, 0, 10, 0, -1, -1);
    map_mode = 2;
    do_run("unsafe_corner0", 100, 200, 0, 0, 4, 0, -1, -1);

    map_mode = 0;
    do_run("clamp_edge", 392, 590, 0, 0, 10, 1, -1, -1);
    chk("clamp_edge_last_x", int'(o_query_x), 399);
    chk("clamp_edge_last_y", int'(o_query_y), 599);
    do_run("out_of_range", 450, 700, 0, 0, 10, 1, -1, -1);
    chk("out_of_range_last_x", int'(o_query_x), 399);
    chk("out_of_range_last_y", int'(o_query_y), 599);

    // Continuous request: accepts at 0, 11, 22, 33 -> pulses at 10, 21, 32
    @(posedge clk); #1;
    i_player_x    = XW'(50);
    i_player_y    = YW'(60);
    i_check_valid = 1'b1;
    pulses        = 0;
    for (int t = 0; t < 35; t++) begin
      @(negedge clk);
      if (o_result_valid) pulses++;
      @(posedge clk); #1;
    end
    i_check_valid = 1'b0;
    chk("back_to_back_pulses", pulses, 3);
    repeat (15) @(posedge clk);

    // Reset during the SAMPLE of corner 1 (relative cycle 5)
    model_en = 1'b0;
    @(posedge clk); #1;
    i_player_x    = XW'(100);
    i_player_y    = YW'(200);
    i_check_valid = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      @(posedge clk); #1;
      i_check_valid = 1'b0;
      if (t == 3) begin
        @(negedge clk);
        chk("pre_reset_query_x", int'(o_query_x), 100);
        chk("pre_reset_query_y", int'(o_query_y), 200);
      end
      if (t == 5) arst = 1'b1;
      if (t == 6) arst = 1'b0;
    end
    @(negedge clk);
    chk("midreset_ready", int'(o_check_ready), 1);
    chk("midreset_result_valid", int'(o_result_valid), 0);
    chk("midreset_safe", int'(o_player_safe), 0);
    chk("midreset_query_x", int'(o_query_x), 0);
    chk("midreset_query_y", int'(o_query_y), 0);
    pulses = 0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (o_result_valid) pulses++;
    end
    chk("midreset_no_result", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
